// File: rtl/moore_seq_gen.sv
// Moore serializer: accepts a WIDTH-bit word on a valid/ready handshake and shifts it out MSB first.
// Optional MOORE_SEQ_GEN_GUARD_ZERO_EN appends one forced x=0 valid bit after every word.
module moore_seq_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GUARD = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        sreg <= load_data;
                        cnt  <= CW'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Without the guard feature, the GUARD encoding is unreachable and falls to IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:  state_nxt = load_valid ? SHIFT : IDLE;
            SHIFT: begin
                if (cnt == '0) begin
`ifdef MOORE_SEQ_GEN_GUARD_ZERO_EN
                    state_nxt = GUARD;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = SHIFT;
                end
            end
`ifdef MOORE_SEQ_GEN_GUARD_ZERO_EN
            GUARD: state_nxt = DONE;
`endif
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        x          = 1'b0;
        x_valid    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  load_ready = 1'b1;
            SHIFT: begin
                x       = sreg[WIDTH-1];
                x_valid = 1'b1;
            end
`ifdef MOORE_SEQ_GEN_GUARD_ZERO_EN
            GUARD: x_valid = 1'b1;
`endif
            DONE:  done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_moore_seq_gen.sv
// Bench for moore_seq_gen: vector table, hand sequences and randomized traffic against a queue model.
module tb_moore_seq_gen;
    localparam int W = 8;
`ifdef MOORE_SEQ_GEN_GUARD_ZERO_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif

    // packed order: x, x_valid, done, load_ready
    typedef struct packed {
        logic x;
        logic xv;
        logic dn;
        logic rdy;
    } outs_t;

    typedef struct {
        logic         lv;
        logic [W-1:0] data;
        outs_t        exp;
    } vec_t;

    localparam outs_t O_IDLE  = 4'b0001;
    localparam outs_t O_GUARD = 4'b0100;
    localparam outs_t O_DONE  = 4'b0010;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_ready, x, x_valid, done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    moore_seq_gen #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .x(x), .x_valid(x_valid), .done(done)
    );

    always #5 clk = ~clk;

    // consecutive-ones detector: y high once two ones in a row have been seen
    logic [1:0] ones;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)    ones <= 2'd0;
        else if (x) ones <= (ones == 2'd2) ? 2'd2 : ones + 2'd1;
        else        ones <= 2'd0;
    end
    wire y = (ones == 2'd2);

    // Reference: each accepted word expands into a queue of expected per-cycle outputs.
    outs_t cur = O_IDLE;
    outs_t q[$];
    logic  prev_xv = 1'b0;
    int    starts[$];

    function automatic outs_t act();
        return {x, x_valid, done, load_ready};
    endfunction

    task automatic check(input string name, input outs_t a, input outs_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s @cyc %0d: x/xv/done/rdy got %b required %b", name, cyc, a, e);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, a, e);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            q.delete();
            cur = O_IDLE;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (cur.rdy && load_valid) begin
            for (int i = W - 1; i >= 0; i--) q.push_back({load_data[i], 3'b100});
            if (G == 1) q.push_back(O_GUARD);
            q.push_back(O_DONE);
            cur = q.pop_front();
        end else begin
            cur = O_IDLE;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        check("model", act(), cur);
        if (x_valid && !prev_xv) starts.push_back(cyc);
        prev_xv = x_valid;
    endtask

    // Async reset asserted between edges; outputs must go idle with no clock.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        check("async_rst", act(), O_IDLE);
        q.delete();
        cur = O_IDLE;
        load_valid = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_idle", act(), O_IDLE);
        end
    endtask

    vec_t vt[W+3];
    logic [W-1:0] b;
    int   ycnt;

    initial begin
        b = 8'b1011_0001;
        vt[0] = '{1'b1, b, {b[W-1], 3'b100}};
        for (int i = 1; i < W; i++) vt[i] = '{1'b0, 8'h00, {b[W-1-i], 3'b100}};
        if (G == 1) begin
            vt[W]   = '{1'b0, 8'h00, O_GUARD};
            vt[W+1] = '{1'b0, 8'h00, O_DONE};
            vt[W+2] = '{1'b0, 8'h00, O_IDLE};
        end else begin
            vt[W]   = '{1'b0, 8'h00, O_DONE};
            vt[W+1] = '{1'b0, 8'h00, O_IDLE};
            vt[W+2] = '{1'b0, 8'h00, O_IDLE};
        end

        repeat (2) @(negedge clk);
        check("reset_state", act(), O_IDLE);
        rst = 1'b0;
        step();

        // single word from the table
        for (int i = 0; i < W + 3; i++) begin
            load_valid = vt[i].lv;
            load_data  = vt[i].data;
            step();
            check("vec", act(), vt[i].exp);
        end

        // busy ignore: load_valid held high, data changes after the first accept
        starts.delete();
        load_valid = 1'b1;
        load_data  = 8'h5A;
        step();
        load_data = 8'hFF;
        repeat (24) step();
        load_valid = 1'b0;
        repeat (W + 4) step();
        check_int("busy_words", (starts.size() >= 2) ? 1 : 0, 1);
        if (starts.size() >= 2) check_int("accept_spacing", starts[1] - starts[0], W + 2 + G);

        // reset mid-word, then a clean word
        load_valid = 1'b1;
        load_data  = 8'hA5;
        step();
        load_valid = 1'b0;
        repeat (2) step();
        async_reset();
        load_valid = 1'b1;
        load_data  = 8'h3C;
        step();
        check("3c_msb", act(), 4'b0100);
        load_valid = 1'b0;
        repeat (W + 3) step();

        // link with detector
        ycnt = 0;
        load_valid = 1'b1;
        load_data  = 8'b0110_1110;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            if (y) ycnt++;
            step();
        end
        check_int("detector_y_cycles", ycnt, 3);
        check_int("detector_y_low_after", int'(y), 0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            load_valid = ($urandom_range(0, 2) == 0);
            load_data  = W'($urandom);
            if ($urandom_range(0, 99) == 0) async_reset();
            else step();
        end
        load_valid = 1'b0;
        repeat (W + 4) step();
        check("final_idle", act(), O_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
